// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by if_stage and its instruction buffer.
package if_stage_pkg;

  localparam int PcWidth        = 32;
  localparam int InstWidth      = 32;
  localparam int IfToIdBusWidth = PcWidth + InstWidth;

  localparam logic [PcWidth-1:0] RESET_PC = 32'h1c00_0000;

  typedef enum logic {
    IF_BUF_DIRECT = 1'b0,
    IF_BUF_HELD   = 1'b1
  } if_buf_state_e;

endpackage

// File: rtl/if_stage_inst_buf.sv
// Instruction hold buffer: keeps the SRAM word alive while ID stalls.
// SRAM data is only valid the cycle after a load, so it is captured then.
module if_inst_buf
  import if_stage_pkg::*;
#(
  parameter int INST_W = InstWidth
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              drain,
  input  logic              if_valid,
  input  logic              id_allowin,
  input  logic              branch_cancel,
  input  logic [INST_W-1:0] rdata,
  output logic [INST_W-1:0] inst
);

  if_buf_state_e     state;
  if_buf_state_e     state_nxt;
  logic              first_cycle;
  logic [INST_W-1:0] inst_buf;
  logic              capture;

  assign capture = (state == IF_BUF_DIRECT) & first_cycle
                 & if_valid & ~id_allowin & ~branch_cancel;

  // State, first-cycle flag and captured instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IF_BUF_DIRECT;
      first_cycle <= 1'b0;
      inst_buf    <= '0;
    end else begin
      state       <= state_nxt;
      first_cycle <= load;
      if (capture) inst_buf <= rdata;
    end
  end

  // Enter HELD on a stalled first cycle, leave on any IF turnover.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IF_BUF_DIRECT:
        if (capture) state_nxt = IF_BUF_HELD;
      IF_BUF_HELD:
        if (load | drain | branch_cancel)
          state_nxt = IF_BUF_DIRECT;
    endcase
  end

  // Select the live SRAM word or the held copy.
  always_comb begin
    inst = rdata;
    if (state == IF_BUF_HELD) inst = inst_buf;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC/valid registers, pre-IF/ID handshake
// and synchronous instruction-SRAM request.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int PC_W   = PcWidth,
  parameter int INST_W = InstWidth,
  parameter logic [PC_W-1:0] RESET_PC = if_stage_pkg::RESET_PC
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 preif_to_if_valid_i,
  input  logic [PC_W-1:0]      preif_pc_i,
  input  logic                 id_allowin_i,
  input  logic                 branch_cancel_i,
  input  logic [INST_W-1:0]    inst_sram_rdata_i,
  output logic                 if_allowin_o,
  output logic                 inst_sram_en_o,
  output logic [PC_W-1:0]      inst_sram_addr_o,
  output logic [PC_W-1:0]      pc_o,
  output logic                 if_to_id_valid_o,
  output logic [PC_W+INST_W-1:0] if_to_id_bus_o
);

  localparam logic [PC_W-1:0] PcRst = RESET_PC - PC_W'(4);

  logic              if_valid;
  logic [PC_W-1:0]   if_pc;
  logic              if_ready_go;
  logic              if_allowin;
  logic              load;
  logic              drain;
  logic [INST_W-1:0] inst;

  assign if_ready_go = 1'b1;
  assign if_allowin  = ~if_valid
                     | (if_ready_go & id_allowin_i)
                     | branch_cancel_i;
  assign load  = if_allowin & preif_to_if_valid_i;
  assign drain = if_allowin & ~preif_to_if_valid_i;

  // Valid bit and PC: load a new PC or drain when allowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid <= 1'b0;
      if_pc    <= PcRst;
    end else if (load) begin
      if_valid <= 1'b1;
      if_pc    <= preif_pc_i;
    end else if (drain) begin
      if_valid <= 1'b0;
    end
  end

  if_inst_buf #(
    .INST_W (INST_W)
  ) u_inst_buf (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (load),
    .drain         (drain),
    .if_valid      (if_valid),
    .id_allowin    (id_allowin_i),
    .branch_cancel (branch_cancel_i),
    .rdata         (inst_sram_rdata_i),
    .inst          (inst)
  );

  assign if_allowin_o     = if_allowin;
  assign inst_sram_en_o   = load;
  assign inst_sram_addr_o = preif_pc_i;
  assign pc_o             = if_pc;
  assign if_to_id_valid_o = if_valid & ~branch_cancel_i;
  assign if_to_id_bus_o   = {if_pc, inst};

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage.
// SRAM model returns ~addr after a request, 32'hdeadbeef otherwise.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        pv;
  logic [31:0] ppc;
  logic        ida;
  logic        bc;
  logic [31:0] rdata;
  logic        allowin;
  logic        en;
  logic [31:0] addr;
  logic [31:0] pc;
  logic        vld;
  logic [63:0] bus;

  int n_tests;
  int n_fail;

  if_stage dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .preif_to_if_valid_i (pv),
    .preif_pc_i          (ppc),
    .id_allowin_i        (ida),
    .branch_cancel_i     (bc),
    .inst_sram_rdata_i   (rdata),
    .if_allowin_o        (allowin),
    .inst_sram_en_o      (en),
    .inst_sram_addr_o    (addr),
    .pc_o                (pc),
    .if_to_id_valid_o    (vld),
    .if_to_id_bus_o      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    rdata <= en ? ~addr : 32'hdeadbeef;

  task automatic test_reset();
    rst_n = 1'b0; pv = 1'b0; ppc = 32'h0;
    ida = 1'b1; bc = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if (vld !== 1'b0) begin
      n_fail++; $display("FAIL rst_vld got=%b exp=0", vld);
    end
    n_tests++;
    if (allowin !== 1'b1) begin
      n_fail++; $display("FAIL rst_allowin got=%b exp=1", allowin);
    end
    n_tests++;
    if (pc !== 32'h1bfffffc) begin
      n_fail++; $display("FAIL rst_pc got=%h exp=1bfffffc", pc);
    end
    n_tests++;
    if (en !== 1'b0) begin
      n_fail++; $display("FAIL rst_en0 got=%b exp=0", en);
    end
    pv = 1'b1; #1;
    n_tests++;
    if (en !== 1'b1) begin
      n_fail++; $display("FAIL rst_en1 got=%b exp=1", en);
    end
    pv = 1'b0;
  endtask

  task automatic test_first_fetch();
    @(negedge clk);
    rst_n = 1'b1; pv = 1'b1; ppc = 32'h1c000000; ida = 1'b1;
    #1;
    n_tests++;
    if (en !== 1'b1 || addr !== 32'h1c000000) begin
      n_fail++;
      $display("FAIL ff_req got en=%b addr=%h exp en=1 addr=1c000000",
               en, addr);
    end
    n_tests++;
    if (vld !== 1'b0) begin
      n_fail++; $display("FAIL ff_vld0 got=%b exp=0", vld);
    end
    @(negedge clk);
    pv = 1'b0; #1;
    n_tests++;
    if (vld !== 1'b1 || bus !== 64'h1c000000_e3ffffff) begin
      n_fail++;
      $display("FAIL ff_bus got vld=%b bus=%h exp vld=1 bus=1c000000e3ffffff",
               vld, bus);
    end
    @(negedge clk); #1;
    n_tests++;
    if (vld !== 1'b0) begin
      n_fail++; $display("FAIL ff_drain got=%b exp=0", vld);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [3];
    pcs[0] = 32'h1c000000;
    pcs[1] = 32'h1c000004;
    pcs[2] = 32'h1c000008;
    ida = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pv  = (i < 3);
      ppc = (i < 3) ? pcs[i] : 32'h0;
      #1;
      if (i > 0) begin
        n_tests++;
        if (vld !== 1'b1 || bus !== {pcs[i-1], ~pcs[i-1]}
            || pc !== pcs[i-1]) begin
          n_fail++;
          $display("FAIL b2b_%0d got vld=%b bus=%h pc=%h exp bus=%h",
                   i, vld, bus, pc, {pcs[i-1], ~pcs[i-1]});
        end
      end
      if (i < 3) begin
        n_tests++;
        if (en !== 1'b1 || addr !== pcs[i]) begin
          n_fail++;
          $display("FAIL b2b_req%0d got en=%b addr=%h exp en=1 addr=%h",
                   i, en, addr, pcs[i]);
        end
      end
    end
    @(negedge clk); pv = 1'b0; #1;
    n_tests++;
    if (vld !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end got=%b exp=0", vld);
    end
  endtask

  task automatic test_stall_and_cancel();
    @(negedge clk);
    pv = 1'b1; ppc = 32'h1c000004; ida = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ida = 1'b0; pv = 1'b1; ppc = 32'h1c000008; #1;
      n_tests++;
      if (vld !== 1'b1 || bus !== 64'h1c000004_e3fffffb) begin
        n_fail++;
        $display("FAIL stall_%0d got vld=%b bus=%h exp bus=1c000004e3fffffb",
                 k, vld, bus);
      end
      n_tests++;
      if (en !== 1'b0 || allowin !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hs_%0d got en=%b allowin=%b exp 0 0",
                 k, en, allowin);
      end
    end
    @(negedge clk);
    ida = 1'b1; #1;
    n_tests++;
    if (vld !== 1'b1 || bus !== 64'h1c000004_e3fffffb || en !== 1'b1) begin
      n_fail++;
      $display("FAIL release got vld=%b bus=%h en=%b", vld, bus, en);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      ida = 1'b0; pv = 1'b0; #1;
      n_tests++;
      if (vld !== 1'b1 || bus !== 64'h1c000008_e3fffff7) begin
        n_fail++;
        $display("FAIL hold8_%0d got vld=%b bus=%h exp bus=1c000008e3fffff7",
                 k, vld, bus);
      end
    end
    @(negedge clk);
    bc = 1'b1; pv = 1'b1; ppc = 32'h1c000100; #1;
    n_tests++;
    if (vld !== 1'b0) begin
      n_fail++; $display("FAIL cancel_vld got=%b exp=0", vld);
    end
    n_tests++;
    if (allowin !== 1'b1 || en !== 1'b1 || addr !== 32'h1c000100) begin
      n_fail++;
      $display("FAIL cancel_req got allowin=%b en=%b addr=%h", allowin, en, addr);
    end
    @(negedge clk);
    bc = 1'b0; pv = 1'b0; ida = 1'b1; #1;
    n_tests++;
    if (vld !== 1'b1 || bus !== 64'h1c000100_e3fffeff) begin
      n_fail++;
      $display("FAIL cancel_tgt got vld=%b bus=%h exp bus=1c000100e3fffeff",
               vld, bus);
    end
    @(negedge clk); #1;
  endtask

  task automatic test_cancel_no_preif();
    @(negedge clk);
    pv = 1'b1; ppc = 32'h1c000200; ida = 1'b1;
    @(negedge clk);
    pv = 1'b0; bc = 1'b1; #1;
    n_tests++;
    if (vld !== 1'b0 || allowin !== 1'b1 || en !== 1'b0) begin
      n_fail++;
      $display("FAIL cnp_cycle got vld=%b allowin=%b en=%b exp 0 1 0",
               vld, allowin, en);
    end
    @(negedge clk);
    bc = 1'b0; #1;
    n_tests++;
    if (vld !== 1'b0 || pc !== 32'h1c000200) begin
      n_fail++;
      $display("FAIL cnp_after got vld=%b pc=%h exp 0 1c000200", vld, pc);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    pv = 1'b1; ppc = 32'h1c000300; ida = 1'b1;
    @(negedge clk);
    pv = 1'b0; ida = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if (vld !== 1'b1 || bus !== 64'h1c000300_e3fffcff) begin
      n_fail++;
      $display("FAIL ar_pre got vld=%b bus=%h exp bus=1c000300e3fffcff",
               vld, bus);
    end
    #1 rst_n = 1'b0; #1;
    n_tests++;
    if (vld !== 1'b0 || pc !== 32'h1bfffffc || allowin !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_async got vld=%b pc=%h allowin=%b exp 0 1bfffffc 1",
               vld, pc, allowin);
    end
    @(negedge clk);
    rst_n = 1'b1; ida = 1'b1; pv = 1'b1; ppc = 32'h1c000000; #1;
    n_tests++;
    if (en !== 1'b1 || addr !== 32'h1c000000 || pc !== 32'h1bfffffc) begin
      n_fail++;
      $display("FAIL ar_first got en=%b addr=%h pc=%h", en, addr, pc);
    end
    @(negedge clk);
    pv = 1'b0; #1;
    n_tests++;
    if (vld !== 1'b1 || bus !== 64'h1c000000_e3ffffff) begin
      n_fail++;
      $display("FAIL ar_fetch got vld=%b bus=%h", vld, bus);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_first_fetch();
    test_back_to_back();
    test_stall_and_cancel();
    test_cancel_no_preif();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
